// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data-bit count and a clog2 helper.
// Used by uart_transmitter and uart_receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned FRAME_BITS = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous input FIFO for the UART transmitter; pointers carry one extra
// wrap bit so full/empty are told apart by the MSB.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter with input FIFO: 8N1 framing, or 8E1 when UART_TX_PARITY_EN
// is defined (adds an even-parity bit after the data bits).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int unsigned CPB    = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W = (clog2(CPB) < 1) ? 1 : clog2(CPB);
    localparam int unsigned BIT_W  = clog2(FRAME_BITS);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       baud_last;
    logic       load;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (data_in_valid),
        .data_i  (data_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data_in_ready = !fifo_full;
    assign serial_out    = serial_q;
    assign busy          = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // serial_d is derived from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        fifo_pop  = 1'b0;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        baud_last = (baud_q == BAUD_W'(CPB - 1));

        if (state_q != ST_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                baud_d   = '0;
                serial_d = 1'b1;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d  = ST_DATA;
                    bit_d    = '0;
                    serial_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        serial_d = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d  = ST_STOP;
                    serial_d = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        serial_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = ST_START;
            baud_d   = '0;
            serial_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
        end

        busy_d = (state_d != ST_IDLE) || !fifo_empty;
    end

endmodule
